// File: rtl/pingpang_pkg.sv
// Shared definitions for the ping-pong read/write controllers: state encoding,
// burst geometry helpers and a ceiling-log2 function.
package pingpang_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE_S = 3'd1,
    READ1 = 3'd2,
    READ2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int burst_bytes(input int len, input int dw);
    return (len * dw) / 8;
  endfunction

  // Each engine skips over the other engine's burst.
  function automatic int address_change(input int len, input int dw);
    return 2 * burst_bytes(len, dw);
  endfunction

endpackage

// File: rtl/pingpang_throttle.sv
// Hysteresis throttle: set at or above the warning level, released only once
// the sink drains to the cancel level.
module pingpang_throttle #(
  parameter int FIFO_Counter_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FIFO_Counter_WIDTH-1:0] fifo_cnt,
  input  logic [FIFO_Counter_WIDTH-1:0] thres,
  input  logic [FIFO_Counter_WIDTH-1:0] cancel,
  output logic                          throttled
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      throttled <= 1'b0;
    end else if (fifo_cnt >= thres) begin
      throttled <= 1'b1;
    end else if (fifo_cnt <= cancel) begin
      throttled <= 1'b0;
    end
  end

endmodule

// File: rtl/pingpang_reader.sv
// Ping-pong read controller: engine 1 owns even bursts, engine 2 odd bursts;
// beats are drained one burst at a time so the merged stream stays in order.
module pingpang_reader
  import pingpang_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH         = 32,
  parameter int FIFO_Counter_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         End_ADDR,
  input  logic [FIFO_Counter_WIDTH-1:0] FIFO_Counter,
  input  logic [FIFO_Counter_WIDTH-1:0] WARNING_THRES,
  input  logic [FIFO_Counter_WIDTH-1:0] WARNING_CANCEL_THRES,
  output logic                          INIT_AXI_TXN_1,
  output logic                          INIT_AXI_TXN_2,
  input  logic                          INIT_AXI_TXN_DONE_1,
  input  logic                          INIT_AXI_TXN_DONE_2,
  output logic [ADDR_WIDTH-1:0]         BIAS_ADDR_1,
  output logic [ADDR_WIDTH-1:0]         BIAS_ADDR_2,
  output logic                          Rd_en_1,
  output logic                          Rd_en_2,
  input  logic                          Data_valid_1,
  input  logic                          Data_valid_2,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] Data_1,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] Data_2,
  output logic [C_M_AXI_DATA_WIDTH-1:0] data,
  output logic                          data_en,
  output logic                          Read_done,
  output logic                          burst_err,
  output logic [2:0]                    current_state
);

  localparam int BB    = burst_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH);
  localparam int CNT_W = clogb2(C_M_AXI_BURST_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] BB_A   = ADDR_WIDTH'(BB);
  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(address_change(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH));

  state_t           state;
  logic             start_q;
  logic             throttled;
  logic [CNT_W-1:0] beat_cnt;
  logic             pend_1, pend_2;
  logic             out_1, out_2;
  logic             done_1, done_2;
  logic             acc_1, acc_2;
  logic             ev_1, ev_2;

  // Offsets are burst-aligned, so sub-burst bits of End_ADDR never change the outcome.
  function automatic logic legal(input logic [ADDR_WIDTH-1:0] off,
                                 input logic [ADDR_WIDTH-1:0] lim);
    logic [ADDR_WIDTH:0] top;
    top = {1'b0, off} + {1'b0, BB_A};
    return top <= {1'b0, lim};
  endfunction

  function automatic logic count_bad(input logic [CNT_W-1:0] cnt, input logic acc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{CNT_W{1'b0}}, acc};
    return sum != (CNT_W+1)'(C_M_AXI_BURST_LEN);
  endfunction

  pingpang_throttle #(
    .FIFO_Counter_WIDTH(FIFO_Counter_WIDTH)
  ) u_throttle (
    .clk      (clk),
    .rst_n    (rst_n),
    .fifo_cnt (FIFO_Counter),
    .thres    (WARNING_THRES),
    .cancel   (WARNING_CANCEL_THRES),
    .throttled(throttled)
  );

  assign Rd_en_1       = (state == READ1) && !throttled;
  assign Rd_en_2       = (state == READ2) && !throttled;
  assign acc_1         = Data_valid_1 && Rd_en_1;
  assign acc_2         = Data_valid_2 && Rd_en_2;
  assign ev_1          = INIT_AXI_TXN_DONE_1 || done_1;
  assign ev_2          = INIT_AXI_TXN_DONE_2 || done_2;
  assign current_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      INIT_AXI_TXN_1 <= 1'b0;
      INIT_AXI_TXN_2 <= 1'b0;
      BIAS_ADDR_1    <= '0;
      BIAS_ADDR_2    <= BB_A;
      data           <= '0;
      data_en        <= 1'b0;
      Read_done      <= 1'b0;
      burst_err      <= 1'b0;
      beat_cnt       <= '0;
      pend_1         <= 1'b0;
      pend_2         <= 1'b0;
      out_1          <= 1'b0;
      out_2          <= 1'b0;
      done_1         <= 1'b0;
      done_2         <= 1'b0;
    end else begin
      start_q        <= start;
      INIT_AXI_TXN_1 <= 1'b0;
      INIT_AXI_TXN_2 <= 1'b0;
      data_en        <= 1'b0;

      // Prefetch: an engine relaunches as soon as its previous burst has drained.
      if ((state == READ1 || state == READ2) && !throttled) begin
        if (pend_1 && !out_1) begin
          INIT_AXI_TXN_1 <= 1'b1;
          pend_1         <= 1'b0;
          out_1          <= 1'b1;
        end
        if (pend_2 && !out_2) begin
          INIT_AXI_TXN_2 <= 1'b1;
          pend_2         <= 1'b0;
          out_2          <= 1'b1;
        end
      end

      // A completion outside its own phase is held until that phase is reached;
      // it is only tolerated when it coincides with the active engine finishing.
      if (INIT_AXI_TXN_DONE_1 && state != READ1) begin
        done_1 <= 1'b1;
        if (!(INIT_AXI_TXN_DONE_2 && state == READ2)) burst_err <= 1'b1;
      end
      if (INIT_AXI_TXN_DONE_2 && state != READ2) begin
        done_2 <= 1'b1;
        if (!(INIT_AXI_TXN_DONE_1 && state == READ1)) burst_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          Read_done <= 1'b0;
          if (start && !start_q) begin
            BIAS_ADDR_1 <= '0;
            BIAS_ADDR_2 <= BB_A;
            burst_err   <= 1'b0;
            beat_cnt    <= '0;
            pend_1      <= 1'b0;
            pend_2      <= 1'b0;
            out_1       <= 1'b0;
            out_2       <= 1'b0;
            done_1      <= 1'b0;
            done_2      <= 1'b0;
            if (legal('0, End_ADDR)) begin
              state <= PRE_S;
            end else begin
              state     <= DONE;
              Read_done <= 1'b1;
            end
          end
        end

        PRE_S: begin
          INIT_AXI_TXN_1 <= 1'b1;
          out_1          <= 1'b1;
          if (legal(BIAS_ADDR_2, End_ADDR)) begin
            INIT_AXI_TXN_2 <= 1'b1;
            out_2          <= 1'b1;
          end
          state <= READ1;
        end

        READ1: begin
          if (acc_1) begin
            data     <= Data_1;
            data_en  <= 1'b1;
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (ev_1) begin
            if (count_bad(beat_cnt, acc_1)) burst_err <= 1'b1;
            beat_cnt    <= '0;
            done_1      <= 1'b0;
            out_1       <= 1'b0;
            BIAS_ADDR_1 <= BIAS_ADDR_1 + STEP_A;
            if (legal(BIAS_ADDR_1 + STEP_A, End_ADDR)) pend_1 <= 1'b1;
            if (out_2 || pend_2) begin
              state <= READ2;
            end else begin
              state     <= DONE;
              Read_done <= 1'b1;
            end
          end
        end

        READ2: begin
          if (acc_2) begin
            data     <= Data_2;
            data_en  <= 1'b1;
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (ev_2) begin
            if (count_bad(beat_cnt, acc_2)) burst_err <= 1'b1;
            beat_cnt    <= '0;
            done_2      <= 1'b0;
            out_2       <= 1'b0;
            BIAS_ADDR_2 <= BIAS_ADDR_2 + STEP_A;
            if (legal(BIAS_ADDR_2 + STEP_A, End_ADDR)) pend_2 <= 1'b1;
            if (out_1 || pend_1) begin
              state <= READ1;
            end else begin
              state     <= DONE;
              Read_done <= 1'b1;
            end
          end
        end

        DONE: begin
          Read_done <= 1'b1;
          if (!start) begin
            state     <= IDLE;
            Read_done <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpang_reader.sv
// Directed bench for pingpang_reader: two behavioural AXI read engines, an
// expected-stream model built from the burst layout, and literal pins per run.
module tb_pingpang_reader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FW = 8;
  localparam int BL = 16;
  localparam int BB = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] End_ADDR = '0;
  logic [FW-1:0] FIFO_Counter = '0;
  logic [FW-1:0] WARNING_THRES = 8'd192;
  logic [FW-1:0] WARNING_CANCEL_THRES = 8'd64;
  logic          INIT_AXI_TXN_1, INIT_AXI_TXN_2;
  logic          INIT_AXI_TXN_DONE_1, INIT_AXI_TXN_DONE_2;
  logic [AW-1:0] BIAS_ADDR_1, BIAS_ADDR_2;
  logic          Rd_en_1, Rd_en_2;
  logic          Data_valid_1, Data_valid_2;
  logic [DW-1:0] Data_1, Data_2;
  logic [DW-1:0] data;
  logic          data_en, Read_done, burst_err;
  logic [2:0]    current_state;

  always #5 clk = ~clk;

  pingpang_reader dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .End_ADDR            (End_ADDR),
    .FIFO_Counter        (FIFO_Counter),
    .WARNING_THRES       (WARNING_THRES),
    .WARNING_CANCEL_THRES(WARNING_CANCEL_THRES),
    .INIT_AXI_TXN_1      (INIT_AXI_TXN_1),
    .INIT_AXI_TXN_2      (INIT_AXI_TXN_2),
    .INIT_AXI_TXN_DONE_1 (INIT_AXI_TXN_DONE_1),
    .INIT_AXI_TXN_DONE_2 (INIT_AXI_TXN_DONE_2),
    .BIAS_ADDR_1         (BIAS_ADDR_1),
    .BIAS_ADDR_2         (BIAS_ADDR_2),
    .Rd_en_1             (Rd_en_1),
    .Rd_en_2             (Rd_en_2),
    .Data_valid_1        (Data_valid_1),
    .Data_valid_2        (Data_valid_2),
    .Data_1              (Data_1),
    .Data_2              (Data_2),
    .data                (data),
    .data_en             (data_en),
    .Read_done           (Read_done),
    .burst_err           (burst_err),
    .current_state       (current_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Engine models: capture handshakes on the rising edge, drive on the falling edge.
  logic [AW-1:0] e_base [2];
  int            e_idx [2];
  int            e_rem [2];
  bit            e_act [2];
  bit            e1_short = 1'b0;
  int            e1_cnt = 0;

  initial begin
    Data_valid_1 = 1'b0; Data_valid_2 = 1'b0;
    INIT_AXI_TXN_DONE_1 = 1'b0; INIT_AXI_TXN_DONE_2 = 1'b0;
    Data_1 = '0; Data_2 = '0;
    for (int i = 0; i < 2; i++) begin
      e_act[i] = 1'b0; e_rem[i] = 0; e_idx[i] = 0; e_base[i] = '0;
    end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        e_act[0] = 1'b0; e_act[1] = 1'b0;
      end else begin
        if (Data_valid_1 && Rd_en_1) begin e_idx[0]++; e_rem[0]--; end
        if (Data_valid_2 && Rd_en_2) begin e_idx[1]++; e_rem[1]--; end
        if (INIT_AXI_TXN_1) begin
          e_act[0] = 1'b1; e_base[0] = BIAS_ADDR_1; e_idx[0] = 0;
          e_rem[0] = (e1_short && e1_cnt == 0) ? BL - 1 : BL;
          e1_cnt++;
        end
        if (INIT_AXI_TXN_2) begin
          e_act[1] = 1'b1; e_base[1] = BIAS_ADDR_2; e_idx[1] = 0; e_rem[1] = BL;
        end
      end
      @(negedge clk);
      INIT_AXI_TXN_DONE_1 = e_act[0] && e_rem[0] == 0;
      if (INIT_AXI_TXN_DONE_1) e_act[0] = 1'b0;
      Data_valid_1 = e_act[0] && e_rem[0] > 0;
      Data_1 = e_base[0] + DW'(e_idx[0]);
      INIT_AXI_TXN_DONE_2 = e_act[1] && e_rem[1] == 0;
      if (INIT_AXI_TXN_DONE_2) e_act[1] = 1'b0;
      Data_valid_2 = e_act[1] && e_rem[1] > 0;
      Data_2 = e_base[1] + DW'(e_idx[1]);
    end
  end

  // Throttle model straight from the hysteresis rule.
  bit mthr = 1'b0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) mthr = 1'b0;
    else if (FIFO_Counter >= WARNING_THRES) mthr = 1'b1;
    else if (FIFO_Counter <= WARNING_CANCEL_THRES) mthr = 1'b0;
  end

  logic [DW-1:0] exp_q [$];
  int beats_seen = 0;
  int init1_n = 0;
  int init2_n = 0;
  int last_st = 0;
  int entry_st = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (INIT_AXI_TXN_1) init1_n++;
      if (INIT_AXI_TXN_2) init2_n++;
      if (data_en) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_beat: got data %0d expected no beat", data);
        end else begin
          check("stream_data", data, exp_q.pop_front());
        end
      end
      if (Rd_en_1 || Rd_en_2) begin
        check("rden_while_throttled", mthr, 0);
        check("rden_exclusive", Rd_en_1 && Rd_en_2, 0);
      end
      if (current_state == 3'd4 && last_st != 4) entry_st = last_st;
      last_st = int'(current_state);
    end
  end

  int snap_b, snap_i1, snap_i2, run_nb;
  bit run_short;

  task automatic begin_run(input int end_addr, input bit short1);
    int len;
    End_ADDR = AW'(end_addr);
    e1_short = short1;
    e1_cnt = 0;
    run_nb = end_addr / BB;
    run_short = short1;
    exp_q.delete();
    for (int k = 0; k < run_nb; k++) begin
      len = (short1 && k == 0) ? BL - 1 : BL;
      for (int b = 0; b < len; b++) exp_q.push_back(DW'(k * BB + b));
    end
    snap_b = beats_seen; snap_i1 = init1_n; snap_i2 = init2_n;
    start = 1'b1;
  endtask

  task automatic finish_run(output int beats, output int i1, output int i2);
    int n;
    n = 0;
    while (!Read_done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("read_done", Read_done, 1);
    @(negedge clk);
    @(negedge clk);
    beats = beats_seen - snap_b;
    i1 = init1_n - snap_i1;
    i2 = init2_n - snap_i2;
    check("exp_left", exp_q.size(), 0);
    check("burst_err_end", burst_err, run_short);
    check("init1_count", i1, (run_nb + 1) / 2);
    check("init2_count", i2, run_nb / 2);
    check("bias1_final", BIAS_ADDR_1, 128 * ((run_nb + 1) / 2));
    check("bias2_final", BIAS_ADDR_2, 64 + 128 * (run_nb / 2));
    check("held_in_done", current_state, 4);
    check("entry_state", entry_st, run_nb == 0 ? 0 : ((run_nb % 2) ? 2 : 3));
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_after", current_state, 0);
    check("read_done_clr", Read_done, 0);
    check("burst_err_sticky", burst_err, run_short);
  endtask

  task automatic stall_window(input string tag);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check({tag, "_rden1"}, Rd_en_1, 0);
      check({tag, "_rden2"}, Rd_en_2, 0);
      check({tag, "_data_en"}, data_en, 0);
      check({tag, "_init"}, INIT_AXI_TXN_1 || INIT_AXI_TXN_2, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, i1, i2, n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", current_state, 0);
    check("rst_bias1", BIAS_ADDR_1, 0);
    check("rst_bias2", BIAS_ADDR_2, 64);
    check("rst_data", data, 0);
    check("rst_data_en", data_en, 0);
    check("rst_read_done", Read_done, 0);
    check("rst_burst_err", burst_err, 0);
    check("rst_init", INIT_AXI_TXN_1 || INIT_AXI_TXN_2, 0);

    // Four bursts, back-to-back engines.
    begin_run(256, 1'b0);
    finish_run(b, i1, i2);
    check("t1_beats", b, 64);
    check("t1_init1", i1, 2);
    check("t1_init2", i2, 2);
    check("t1_bias1", BIAS_ADDR_1, 256);
    check("t1_bias2", BIAS_ADDR_2, 320);

    // Three bursts: ends from READ1.
    begin_run(192, 1'b0);
    finish_run(b, i1, i2);
    check("t2_beats", b, 48);
    check("t2_init2", i2, 1);
    check("t2_entry", entry_st, 2);
    check("t2_bias2", BIAS_ADDR_2, 192);

    // Engine 1 finishes its first burst one beat short.
    begin_run(256, 1'b1);
    finish_run(b, i1, i2);
    check("t4_beats", b, 63);
    check("t4_err_sticky", burst_err, 1);

    // Throttle with hysteresis mid-burst.
    begin_run(256, 1'b0);
    repeat (2) @(negedge clk);
    check("t3_err_cleared", burst_err, 0);
    n = 0;
    while (beats_seen - snap_b < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_reached_beats", (beats_seen - snap_b) >= 5, 1);
    FIFO_Counter = 8'd200;
    repeat (2) @(negedge clk);
    stall_window("t3_hi");
    FIFO_Counter = 8'd100;
    stall_window("t3_mid");
    FIFO_Counter = 8'd64;
    finish_run(b, i1, i2);
    check("t3_beats", b, 64);
    FIFO_Counter = 8'd0;

    // Region smaller than one burst.
    begin_run(32, 1'b0);
    finish_run(b, i1, i2);
    check("t6_beats", b, 0);
    check("t6_inits", i1 + i2, 0);
    check("t6_entry", entry_st, 0);

    // Asynchronous reset during READ2.
    begin_run(256, 1'b0);
    n = 0;
    while (current_state != 3'd3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_read2", current_state, 3);
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_state", current_state, 0);
    check("t5_bias1", BIAS_ADDR_1, 0);
    check("t5_bias2", BIAS_ADDR_2, 64);
    check("t5_data", data, 0);
    check("t5_data_en", data_en, 0);
    check("t5_init", INIT_AXI_TXN_1 || INIT_AXI_TXN_2, 0);
    check("t5_rden2", Rd_en_2, 0);
    check("t5_read_done", Read_done, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("t5_idle_after", current_state, 0);
    check("t5_no_beats", data_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
